keypad_scanner: RTL and testbench



---
 rtl/calc_pkg.sv | 58 +++++
 rtl/keypad_debounce.sv | 51 +++++
 rtl/keypad_scanner.sv | 195 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: keycodes, keypad index mapping and scanner types.
package calc_pkg;

  localparam logic [4:0] KEY_NONE          = 5'h00;
  localparam logic [4:0] KEY_MEMORY_RECALL = 5'h01;
  localparam logic [4:0] KEY_MEMORY_STORE  = 5'h02;
  localparam logic [4:0] KEY_CA            = 5'h04;
  localparam logic [4:0] KEY_ADD           = 5'h0a;
  localparam logic [4:0] KEY_MULTIPLY      = 5'h0b;
  localparam logic [4:0] KEY_EQUAL         = 5'h0c;
  localparam logic [4:0] KEY_DIGIT_BASE    = 5'h10;

  // Highest populated matrix position; 22..24 have no switch fitted.
  localparam logic [4:0] KEY_LAST_INDEX    = 5'd21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_HELD
  } scan_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } sweep_kind_e;

  // idx is only meaningful for RES_KEY and is kept zero otherwise so that
  // whole-struct equality compares the kinds alone.
  typedef struct packed {
    sweep_kind_e kind;
    logic [4:0]  idx;
  } sweep_result_t;

  function automatic logic key_populated(input logic [4:0] idx);
    return idx <= KEY_LAST_INDEX;
  endfunction

  function automatic logic [4:0] key_to_code(input logic [4:0] idx);
    logic [4:0] code;
    code = KEY_NONE;
    if (idx < 5'd16) begin
      code = KEY_DIGIT_BASE + idx;
    end else begin
      case (idx)
        5'd16:   code = KEY_ADD;
        5'd17:   code = KEY_MULTIPLY;
        5'd18:   code = KEY_EQUAL;
        5'd19:   code = KEY_CA;
        5'd20:   code = KEY_MEMORY_STORE;
        5'd21:   code = KEY_MEMORY_RECALL;
        default: code = KEY_NONE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-sweep debouncer: remembers the last sweep result and how many
// consecutive sweeps have produced it, saturating at DEBOUNCE_SWEEPS.
module keypad_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sweep_done,
  input  sweep_result_t sweep_result,
  output logic          result_valid,
  output logic          stable,
  output sweep_result_t result
);

  localparam int SW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SWEEPS);

  logic [SW-1:0] stab_reg, stab_next;
  sweep_result_t prev_reg;
  logic          valid_reg;

  // Next stability count: grow on a repeat of the previous result, else restart at 1.
  always_comb begin
    stab_next = SW'(1);
    if (sweep_result == prev_reg) begin
      stab_next = (stab_reg == STAB_MAX) ? STAB_MAX : stab_reg + 1'b1;
    end
  end

  // Capture each completed sweep; valid_reg flags the cycle the new state is visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      stab_reg  <= '0;
      prev_reg  <= '{kind: RES_NONE, idx: 5'd0};
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= sweep_done;
      if (sweep_done) begin
        stab_reg <= stab_next;
        prev_reg <= sweep_result;
      end
    end
  end

  assign result_valid = valid_reg;
  assign stable       = (stab_reg == STAB_MAX);
  assign result       = prev_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 5x5 keypad scanner: column drive, row sampling, sweep classification and
// the press/hold/release FSM that feeds calc_logic's keycode/newkey.
// Optional build macro KEYPAD_AUTOREPEAT_EN enables digit auto-repeat.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_SWEEPS = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [4:0] col_n,
  input  logic [4:0] row_n,
  output logic [4:0] keycode,
  output logic       newkey
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [4:0]    row_meta_reg, row_sync_reg;
  logic [2:0]    col_reg;
  logic [DW-1:0] dwell_reg;
  logic          sample, sweep_end;
  logic [4:0]    col_base;
  logic [4:0]    row_hit;
  logic [4:0]    row_idx [5];
  logic [1:0]    col_cnt, tot_cnt, acc_cnt_reg;
  logic [4:0]    col_idx, tot_idx, acc_idx_reg;
  logic [2:0]    tot_sum;
  sweep_result_t sweep_res, deb_result;
  logic          deb_valid, deb_stable;

  scan_state_e      state_reg, state_next;
  logic [4:0]       keycode_reg, keycode_next, deb_code;
  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next, rpt_cnt_inc, rpt_thr;
  logic             rpt_active_reg, rpt_active_next;
  logic             press_seen, release_seen;

  // Two-flop synchronizer; rows idle high (pulled up).
  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= row_n;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign sample    = (dwell_reg == DWELL_LAST);
  assign sweep_end = sample && (col_reg == 3'd4);

  // Column/dwell counters: each column is driven for SCAN_DIV cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_reg   <= 3'd0;
      dwell_reg <= '0;
    end else if (sample) begin
      dwell_reg <= '0;
      col_reg   <= (col_reg == 3'd4) ? 3'd0 : col_reg + 3'd1;
    end else begin
      dwell_reg <= dwell_reg + 1'b1;
    end
  end

  assign col_n    = ~(5'b00001 << col_reg);
  assign col_base = 5'(col_reg) * 5'd5;

  // Per-row key index and hit flag for the column currently driven.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_row
      assign row_idx[gi] = col_base + 5'(gi);
      assign row_hit[gi] = ~row_sync_reg[gi] && key_populated(row_idx[gi]);
    end
  endgenerate

  // Merge this column's hits with the sweep so far and classify the sweep.
  always_comb begin
    col_cnt = 2'd0;
    col_idx = 5'd0;
    for (int r = 0; r < 5; r++) begin
      if (row_hit[r]) begin
        col_idx = row_idx[r];
        if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
      end
    end
    tot_sum = {1'b0, acc_cnt_reg} + {1'b0, col_cnt};
    tot_cnt = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    tot_idx = (col_cnt != 2'd0) ? col_idx : acc_idx_reg;
    sweep_res = '{kind: RES_NONE, idx: 5'd0};
    if (tot_cnt == 2'd1) sweep_res = '{kind: RES_KEY, idx: tot_idx};
    else if (tot_cnt == 2'd2) sweep_res = '{kind: RES_MULTI, idx: 5'd0};
  end

  // Running key count/index across columns 0..3, cleared at each sweep end.
  always_ff @(posedge clock) begin
    if (reset || sweep_end) begin
      acc_cnt_reg <= 2'd0;
      acc_idx_reg <= 5'd0;
    end else if (sample) begin
      acc_cnt_reg <= tot_cnt;
      acc_idx_reg <= tot_idx;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SWEEPS(DEBOUNCE_SWEEPS)
  ) u_debounce (
    .clock        (clock),
    .reset        (reset),
    .sweep_done   (sweep_end),
    .sweep_result (sweep_res),
    .result_valid (deb_valid),
    .stable       (deb_stable),
    .result       (deb_result)
  );

  assign deb_code     = key_to_code(deb_result.idx);
  assign press_seen   = deb_valid && deb_stable && (deb_result.kind == RES_KEY);
  assign release_seen = deb_valid && deb_stable && (deb_result.kind != RES_KEY);
  assign rpt_cnt_inc  = rpt_cnt_reg + 1'b1;
  assign rpt_thr      = rpt_active_reg ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);

  // Next-state and strobe logic; a stable MULTI counts as no key.
  always_comb begin
    state_next      = state_reg;
    keycode_next    = keycode_reg;
    rpt_cnt_next    = rpt_cnt_reg;
    rpt_active_next = rpt_active_reg;
    newkey          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (press_seen) begin
          keycode_next    = deb_code;
          rpt_active_next = 1'b0;
          state_next      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        newkey       = 1'b1;
        rpt_cnt_next = '0;
        state_next   = ST_HELD;
      end
      ST_HELD: begin
        if (release_seen) begin
          keycode_next = KEY_NONE;
          state_next   = ST_IDLE;
        end else if (deb_valid) begin
          // Only the same stable digit keeps the repeat timer running.
          if (REPEAT_EN && press_seen && (deb_code == keycode_reg) && keycode_reg[4]) begin
            if (rpt_cnt_inc == rpt_thr) begin
              rpt_active_next = 1'b1;
              state_next      = ST_EMIT;
            end else begin
              rpt_cnt_next = rpt_cnt_inc;
            end
          end else begin
            rpt_cnt_next = '0;
          end
        end
      end
      default: state_next = ST_HELD;
    endcase
  end

  // FSM registers; reset lands in HELD so a key held through reset is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_HELD;
      keycode_reg    <= KEY_NONE;
      rpt_cnt_reg    <= '0;
      rpt_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      keycode_reg    <= keycode_next;
      rpt_cnt_reg    <= rpt_cnt_next;
      rpt_active_reg <= rpt_active_next;
    end
  end

  assign keycode = keycode_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Sweep-level bench for keypad_scanner: a keypad model drives row_n from
// col_n, and a per-sweep reference model predicts strobes and keycode.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int RD       = 4;
  localparam int RR       = 2;
  localparam int SWEEP    = 5 * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  col_n, row_n, keycode;
  logic        newkey;
  logic [24:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         m_prev, m_stab, m_since;
  bit         m_holding, m_repeated, exp_strobe;
  logic [4:0] m_code;
  int         test_strobes;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SWEEPS(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
    .keycode(keycode), .newkey(newkey)
  );

  always #5 clock = ~clock;

  // Keypad: a pressed switch pulls its row low while its column is driven low.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        if (!col_n[c] && pressed[5*c+r]) row_n[r] = 1'b0;
  end

  function automatic logic [24:0] bit25(input int k);
    logic [24:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] code_of(input int k);
    if (k < 16) return 5'(16 + k);
    case (k)
      16: return 5'h0a;
      17: return 5'h0b;
      18: return 5'h0c;
      19: return 5'h04;
      20: return 5'h02;
      21: return 5'h01;
      default: return 5'h00;
    endcase
  endfunction

  // -1: no key, -2: several keys, else the single populated index.
  function automatic int classify(input logic [24:0] s);
    int n, idx;
    n = 0; idx = -1;
    for (int k = 0; k < 22; k++) if (s[k]) begin n++; idx = k; end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return idx;
  endfunction

  task automatic model_reset;
    m_prev = -1; m_stab = 0; m_holding = 1'b1; m_code = 5'h00;
    m_since = 0; m_repeated = 1'b0; exp_strobe = 1'b0;
  endtask

  // Applies one complete sweep to the model; exp_strobe/m_code then describe the next sweep window.
  task automatic model_sweep(input logic [24:0] s);
    int  res;
    bit  stable;
    res = classify(s);
    m_stab = (res == m_prev) ? ((m_stab < DEB) ? m_stab + 1 : DEB) : 1;
    m_prev = res;
    stable = (m_stab == DEB);
    exp_strobe = 1'b0;
    if (!m_holding) begin
      if (stable && res >= 0) begin
        exp_strobe = 1'b1; m_code = code_of(res); m_holding = 1'b1;
        m_since = 0; m_repeated = 1'b0;
      end
    end else if (stable && res < 0) begin
      m_holding = 1'b0; m_code = 5'h00;
    end else if (AR && stable && res >= 0 && code_of(res) == m_code && m_code[4]) begin
      m_since++;
      if (m_since == (m_repeated ? RR : RD)) begin
        exp_strobe = 1'b1; m_since = 0; m_repeated = 1'b1;
      end
    end else begin
      m_since = 0;
    end
  endtask

  // Reset held for one rising edge; the sweep restarts on that edge.
  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One sweep window of SWEEP cycles starting at a negedge just after column 0 begins.
  task automatic do_sweep(input logic [24:0] s, input bit chk_col);
    int         hi;
    logic [4:0] code_at, exp_col;
    hi = 0; code_at = 5'h00;
    pressed = s;
    for (int c = 0; c < SWEEP; c++) begin
      if (newkey) begin hi++; code_at = keycode; end
      if (chk_col) begin
        exp_col = ~(5'b00001 << (c / SCAN_DIV));
        n_checks++;
        if (col_n !== exp_col) begin
          n_fail++;
          $display("FAIL col_n cycle %0d: got %b expected %b", c, col_n, exp_col);
        end
      end
      if (c == SWEEP - 1) begin
        n_checks++;
        if (keycode !== m_code) begin
          n_fail++;
          $display("FAIL keycode_hold: got %h expected %h", keycode, m_code);
        end
      end
      @(negedge clock);
    end
    n_checks++;
    if (hi !== (exp_strobe ? 1 : 0)) begin
      n_fail++;
      $display("FAIL strobe_count: got %0d expected %0d (set %h)", hi, exp_strobe ? 1 : 0, s);
    end
    if (exp_strobe) begin
      n_checks++;
      if (code_at !== m_code) begin
        n_fail++;
        $display("FAIL strobe_code: got %h expected %h", code_at, m_code);
      end
    end
    test_strobes += hi;
    model_sweep(s);
  endtask

  task automatic check_total(input string name, input int expected);
    n_checks++;
    if (test_strobes !== expected) begin
      n_fail++;
      $display("FAIL %s total strobes: got %0d expected %0d", name, test_strobes, expected);
    end
    $display("%s: %0d strobes", name, test_strobes);
    test_strobes = 0;
  endtask

  task automatic test_reset;
    do_reset();
    test_strobes = 0;
    n_checks++;
    if (keycode !== 5'h00 || newkey !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got keycode %h newkey %b expected 00 0", keycode, newkey);
    end
    repeat (2) do_sweep('0, 1'b1);
    check_total("test_reset", 0);
  endtask

  task automatic test_single_press;
    repeat (5) do_sweep(bit25(2), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_single_press", 1);
  endtask

  task automatic test_bounce;
    do_sweep(bit25(16), 1'b0);
    do_sweep('0, 1'b0);
    repeat (5) do_sweep(bit25(16), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_bounce", 1);
  endtask

  task automatic test_multi;
    repeat (3) do_sweep(bit25(3) | bit25(17), 1'b0);
    check_total("test_multi_both", 0);
    repeat (3) do_sweep(bit25(3), 1'b0);
    repeat (3) do_sweep(bit25(3) | bit25(18), 1'b0);
    check_total("test_multi_release17", 1);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_multi_add18", 0);
  endtask

  task automatic test_reset_hold;
    repeat (3) do_sweep(bit25(21), 1'b0);
    check_total("test_hold_pre_reset", 1);
    do_reset();
    repeat (3) do_sweep(bit25(21), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_hold_through_reset", 0);
    repeat (3) do_sweep(bit25(21), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_repress", 1);
  endtask

  task automatic test_unpopulated;
    repeat (3) do_sweep(bit25(22), 1'b0);
    repeat (3) do_sweep(bit25(23), 1'b0);
    repeat (3) do_sweep(bit25(24), 1'b0);
    repeat (3) do_sweep(bit25(22) | bit25(23) | bit25(24), 1'b0);
    check_total("test_unpopulated", 0);
    repeat (3) do_sweep(bit25(3) | bit25(22), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_unpopulated_plus3", 1);
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat;
    repeat (12) do_sweep(bit25(5), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_autorepeat_digit", 5);
    repeat (12) do_sweep(bit25(18), 1'b0);
    repeat (3) do_sweep('0, 1'b0);
    check_total("test_autorepeat_function", 1);
  endtask
`endif

  task automatic test_random;
    logic [24:0] s;
    int          hold;
    for (int i = 0; i < 20; i++) begin
      s = '0;
      case ($urandom_range(0, 3))
        0: s = '0;
        1, 2: s[$urandom_range(0, 24)] = 1'b1;
        default: begin
          s[$urandom_range(0, 24)] = 1'b1;
          s[$urandom_range(0, 24)] = 1'b1;
        end
      endcase
      hold = $urandom_range(1, 4);
      repeat (hold) do_sweep(s, 1'b0);
    end
    repeat (3) do_sweep('0, 1'b0);
    $display("test_random: %0d strobes", test_strobes);
    test_strobes = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_reset_hold();
    test_unpopulated();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
